// File: rtl/vga_timing_gen.sv
// VGA-style raster timing generator: free-running h/v counters with a
// single registered output stage for sync, display enable, blanked colour and frame markers.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned COLOR_W  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [3*COLOR_W-1:0] rgb_in,
  output logic [11:0]          pix_x,
  output logic [11:0]          pix_y,
  output logic                 pix_req,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic                 de,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 line_end,
  output logic                 frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0]        h_q, h_d;
  logic [11:0]        v_q, v_d;
  logic               h_wrap;
  logic               v_wrap;
  logic               active;

  logic               de_q, de_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               le_q, le_d;
  logic               fs_q, fs_d;
  logic [COLOR_W-1:0] r_q, r_d;
  logic [COLOR_W-1:0] g_q, g_d;
  logic [COLOR_W-1:0] b_q, b_d;

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);
  assign active = (h_q < H_ACT_END) && (v_q < V_ACT_END);

  // Counter next state: v only moves on an h wrap, so the corner case
  // (H_LAST,V_LAST) -> (0,0) happens on a single edge.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (en) begin
      h_d = h_wrap ? '0 : h_q + 12'd1;
      if (h_wrap) begin
        v_d = v_wrap ? '0 : v_q + 12'd1;
      end
    end
  end

  // Output stage decodes the current counts; syncs hold while stalled.
  always_comb begin
    de_d = 1'b0;
    r_d  = '0;
    g_d  = '0;
    b_d  = '0;
    le_d = 1'b0;
    fs_d = 1'b0;
    hs_d = hs_q;
    vs_d = vs_q;
    if (en) begin
      de_d = active;
      if (active) begin
        r_d = rgb_in[3*COLOR_W-1:2*COLOR_W];
        g_d = rgb_in[2*COLOR_W-1:COLOR_W];
        b_d = rgb_in[COLOR_W-1:0];
      end
      hs_d = ((h_q >= HS_START) && (h_q < HS_END)) ? H_POL : ~H_POL;
      vs_d = ((v_q >= VS_START) && (v_q < VS_END)) ? V_POL : ~V_POL;
      le_d = h_wrap;
      fs_d = (h_q == '0) && (v_q == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q  <= '0;
      v_q  <= '0;
      de_q <= 1'b0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      le_q <= 1'b0;
      fs_q <= 1'b0;
      hs_q <= ~H_POL;
      vs_q <= ~V_POL;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      de_q <= de_d;
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
      le_q <= le_d;
      fs_q <= fs_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
    end
  end

  assign pix_x       = h_q;
  assign pix_y       = v_q;
  assign pix_req     = active;
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign de          = de_q;
  assign red         = r_q;
  assign green       = g_q;
  assign blue        = b_q;
  assign line_end    = le_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a small 16x8 raster: expected output
// stage values are queued when a pixel count is presented and checked after the edge.
module tb_vga_timing_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic [5:0]  rgb_in;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic        pix_req;
  logic        h_sync;
  logic        v_sync;
  logic        de;
  logic [1:0]  red;
  logic [1:0]  green;
  logic [1:0]  blue;
  logic        line_end;
  logic        frame_start;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .COLOR_W(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .rgb_in(rgb_in),
    .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req),
    .h_sync(h_sync), .v_sync(v_sync), .de(de),
    .red(red), .green(green), .blue(blue),
    .line_end(line_end), .frame_start(frame_start)
  );

  typedef struct packed {
    logic       de;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       hs;
    logic       vs;
    logic       le;
    logic       fs;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int mh = 0;
  int mv = 0;
  logic mhs = 1'b1;
  logic mvs = 1'b1;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One pixel clock: present inputs mid-cycle, check counts, queue the
  // expected output stage, then compare it just after the rising edge.
  task automatic step(input logic e, input logic [5:0] rgb);
    exp_t x;
    exp_t o;
    logic act;
    @(negedge clk);
    en = e;
    rgb_in = rgb;
    #1;
    act = (mh < 8) && (mv < 4);
    chk("pix_x", 32'(pix_x), 32'(mh));
    chk("pix_y", 32'(pix_y), 32'(mv));
    chk("pix_req", 32'(pix_req), 32'(act));
    if (e) begin
      mhs = !((mh >= 10) && (mh < 13));
      mvs = !((mv >= 5) && (mv < 7));
    end
    x.de = e && act;
    x.r  = x.de ? rgb[5:4] : 2'b00;
    x.g  = x.de ? rgb[3:2] : 2'b00;
    x.b  = x.de ? rgb[1:0] : 2'b00;
    x.hs = mhs;
    x.vs = mvs;
    x.le = e && (mh == 15);
    x.fs = e && (mh == 0) && (mv == 0);
    sb_q.push_back(x);
    if (e) begin
      if (mh == 15) begin
        mh = 0;
        mv = (mv == 7) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      o = sb_q.pop_front();
      chk("de", 32'(de), 32'(o.de));
      chk("red", 32'(red), 32'(o.r));
      chk("green", 32'(green), 32'(o.g));
      chk("blue", 32'(blue), 32'(o.b));
      chk("h_sync", 32'(h_sync), 32'(o.hs));
      chk("v_sync", 32'(v_sync), 32'(o.vs));
      chk("line_end", 32'(line_end), 32'(o.le));
      chk("frame_start", 32'(frame_start), 32'(o.fs));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_x"}, 32'(pix_x), 32'd0);
    chk({tag, "_y"}, 32'(pix_y), 32'd0);
    chk({tag, "_de"}, 32'(de), 32'd0);
    chk({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
    chk({tag, "_hs"}, 32'(h_sync), 32'd1);
    chk({tag, "_vs"}, 32'(v_sync), 32'd1);
    chk({tag, "_le"}, 32'(line_end), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int fs_cnt;
    int le_cnt;
    int de_cnt;
    int last_fs;
    int fs_gap;
    int n;
    logic corner;

    rst = 1'b0;
    en = 1'b0;
    rgb_in = '0;

    // Asynchronous reset between edges, no clock edge before sampling.
    #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Two full frames with a fixed colour.
    fs_cnt = 0; le_cnt = 0; de_cnt = 0; last_fs = -1; fs_gap = 0;
    for (int i = 0; i < 256; i++) begin
      corner = (mh == 15) && (mv == 7);
      step(1'b1, 6'b110110);
      if (corner) begin
        chk("corner_wrap_x", 32'(pix_x), 32'd0);
        chk("corner_wrap_y", 32'(pix_y), 32'd0);
      end
      if (frame_start) begin
        if (last_fs >= 0) fs_gap = cyc - last_fs;
        last_fs = cyc;
        fs_cnt++;
      end
      if (line_end) le_cnt++;
      if (de) begin
        de_cnt++;
        chk("rgb_split", 32'({red, green, blue}), 32'h36);
      end
    end
    chk("fs_count", 32'(fs_cnt), 32'd2);
    chk("frame_period", 32'(fs_gap), 32'd128);
    chk("le_count", 32'(le_cnt), 32'd16);
    chk("de_count", 32'(de_cnt), 32'd64);

    // Stall at (3,1) with random colour traffic.
    n = 0;
    while (!((mh == 3) && (mv == 1)) && (n < 200)) begin
      step(1'b1, 6'($urandom));
      n++;
    end
    chk("reach_3_1", 32'(n < 200), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 6'($urandom));
      chk("stall_x", 32'(pix_x), 32'd3);
    end
    step(1'b1, 6'($urandom));
    chk("resume_x", 32'(pix_x), 32'd4);
    for (int i = 0; i < 20; i++) step(1'b1, 6'($urandom));

    // Mid-frame reset at (9,2).
    n = 0;
    while (!((mh == 9) && (mv == 2)) && (n < 300)) begin
      step(1'b1, 6'($urandom));
      n++;
    end
    chk("reach_9_2", 32'(n < 300), 32'd1);
    #2;
    en = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    mh = 0; mv = 0; mhs = 1'b1; mvs = 1'b1;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 6'b011011);
    chk("fs_after_rst", 32'(frame_start), 32'd1);
    for (int i = 0; i < 40; i++) step(1'b1, 6'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 1024, meaning visible pixels per line.
REQ-002 Parameter H_FP, default 24, meaning horizontal front porch in pixel clocks.
REQ-003 Parameter H_SYNC, default 136, meaning horizontal sync width in pixel clocks.
REQ-004 Parameter H_BP, default 160, meaning horizontal back porch in pixel clocks.
REQ-005 Parameter V_ACTIVE, default 768, meaning visible lines per frame.
REQ-006 Parameter V_FP, default 3, meaning vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 6, meaning vertical sync width in lines.
REQ-008 Parameter V_BP, default 29, meaning vertical back porch in lines.
REQ-009 Parameter H_POL, default 0, meaning h_sync active level (0 = active-low).
REQ-010 Parameter V_POL, default 0, meaning v_sync active level (0 = active-low).
REQ-011 Parameter COLOR_W, default 1, meaning bits per colour channel.
REQ-012 clk  input  1  pixel clock; all state on rising edge.
REQ-013 rst  input  1  asynchronous, active-high reset.
REQ-014 en  input  1  timing advance enable; low freezes counters.
REQ-015 rgb_in  input  3*COLOR_W  pixel colour for current pix_x/pix_y, {R,G,B} MSB to LSB.
REQ-016 pix_x  output  12  current horizontal count.
REQ-017 pix_y  output  12  current vertical count.
REQ-018 pix_req  output  1  high when the current counts are in the active region.
REQ-019 h_sync, v_sync  output  1 each  registered sync outputs.
REQ-020 de  output  1  registered display enable.
REQ-021 red, green, blue  output  COLOR_W each  registered, blanked colour outputs.
REQ-022 line_end, frame_start  output  1 each  registered single-cycle pulses.

Function
REQ-023 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, each SHALL be at most 4096; every parameter except the polarity parameters SHALL be at least 1.
REQ-024 The h counter SHALL increment by 1 per clk while en=1 and wrap from H_TOTAL-1 to 0.
REQ-025 The v counter SHALL increment only on an h wrap and wrap from V_TOTAL-1 to 0 on the same edge as the h wrap.
REQ-026 pix_x and pix_y SHALL be the registered counter values directly, with no extra delay.
REQ-027 pix_req SHALL be 1 iff h<H_ACTIVE and v<V_ACTIVE (combinational from the counters).
REQ-028 Output stage, one clk after the counts: de=pix_req, and {red,green,blue}=rgb_in when pix_req=1, else all zero.
REQ-029 Output stage, one clk after the counts: h_sync=H_POL iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~H_POL.
REQ-030 Output stage, one clk after the counts: v_sync=V_POL iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else ~V_POL.
REQ-031 Pipeline latency from pix_x/pix_y/rgb_in to colour/de/sync outputs SHALL be exactly 1 clk, and all outputs for a given pixel SHALL be mutually aligned.
REQ-032 line_end SHALL pulse high for one output cycle, aligned with the output of pixel h=H_TOTAL-1.
REQ-033 frame_start SHALL pulse high for one output cycle, aligned with the output of pixel (0,0).
REQ-034 While en=0, the counters SHALL hold.
REQ-035 While en=0, the output stage SHALL drive de=0, colour outputs 0, line_end=0 and frame_start=0.
REQ-036 While en=0, h_sync and v_sync SHALL hold their last values.
REQ-037 When en returns to 1, counting SHALL resume from the held counts with no skipped or repeated pixel.
REQ-038 When h and v wrap simultaneously, the counts SHALL go from (H_TOTAL-1, V_TOTAL-1) to (0,0) in one clk.

Reset
REQ-039 While rst=1, regardless of clk: counters=0, de=0, colours=0, line_end=0, frame_start=0, h_sync=~H_POL, v_sync=~V_POL.
REQ-040 rst asserted mid-frame SHALL abort the frame immediately.
REQ-041 After rst deassertion with en=1, the first counted pixel SHALL be (0,0), and frame_start SHALL pulse on the output cycle after it.

Verification (H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1, COLOR_W=2, polarities 0)
REQ-042 Reset scenario: assert rst asynchronously between edges -> outputs reach their reset values without a clk edge; h_sync=v_sync=1, de=0, colours=0.
REQ-043 Timing scenario: release rst, en=1, rgb_in=6'b110110 -> frame_start high 1 clk after count (0,0); de high for 8 clks per line; red=3, green=1, blue=2; h_sync low when the output count is h=10..12; line_end every 16 clks.
REQ-044 Vertical scenario: run 2 frames -> v_sync low during lines 5..6; frame period 128 clks; pix_y wraps 7->0 while pix_x wraps 15->0 on the same edge.
REQ-045 Stall scenario: drop en for 5 clks at h=3, v=1 -> pix_x holds at 3; de and colours are 0 during the stall; syncs hold; after resume the next count is h=4 with no gaps.
REQ-046 Mid-frame reset scenario: pulse rst at h=9, v=2 -> counts return to (0,0); the next frame_start comes exactly 1 clk after the first counted pixel following release.
